pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the stall-cycle performance counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset is asynchronous and active-high.
REQ-004 id_rs, id_rt  input  3 each  source register numbers of the instruction in decode.
REQ-005 id_rs_valid, id_rt_valid  input  1 each  the corresponding source is read.
REQ-006 idex_memread, idex_wen  input  1 each  ID/EX instruction is a load, and it writes the register file.
REQ-007 idex_rd  input  3  ID/EX destination register.
REQ-008 ex_btake, ex_jump  input  1 each  branch taken or jump resolved in EX.
REQ-009 exmem_memreq  input  1  EX/MEM instruction accesses data memory.
REQ-010 exmem_halt  input  1  EX/MEM instruction is HALT.
REQ-011 mem_done  input  1  data memory completes the current access this cycle.
REQ-012 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  enables for the PC and the pipeline registers.
REQ-013 ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  load a bubble (NOP, all controls 0) into that register on this edge.
REQ-014 halted  output  1  processor has fully stopped.
REQ-015 stall_cnt  output  CNT_W  saturating count of frozen-fetch cycles.

Function
REQ-016 The FSM SHALL have exactly four states: RUN, MEM_WAIT, DRAIN, HALTED.
REQ-017 Outputs SHALL be combinational from state and inputs; state, halted and stall_cnt SHALL be registered.
REQ-018 Load-use hazard: luh = idex_memread & idex_wen & ((id_rs_valid & id_rs==idex_rd) | (id_rt_valid & id_rt==idex_rd)).
REQ-019 Redirect: redir = ex_btake | ex_jump.
REQ-020 Memory stall: mstall = (state==RUN & exmem_memreq & ~mem_done) | (state==MEM_WAIT & ~mem_done).
REQ-021 Priority, highest first: mstall, exmem_halt, redir, luh, normal.
REQ-022 mstall: pc_en, ifid_en, idex_en, exmem_en = 0; memwb_en=1 with memwb_flush=1; all other flushes 0; redir and luh are ignored this cycle.
REQ-023 exmem_halt (RUN, no mstall): pc_en, ifid_en, idex_en = 0; exmem_en=1 with exmem_flush=1; memwb_en=1; next state DRAIN.
REQ-024 redir (RUN, no mstall, no halt): all enables 1; ifid_flush=1 and idex_flush=1; luh is ignored.
REQ-025 luh (RUN, no higher condition): pc_en=0, ifid_en=0; idex_en=1 with idex_flush=1; exmem_en=1, memwb_en=1.
REQ-026 Normal: all enables 1, all flushes 0.
REQ-027 Transitions:
- RUN->MEM_WAIT when exmem_memreq & ~mem_done & ~exmem_halt.
- MEM_WAIT->RUN on mem_done; the release cycle itself SHALL behave as a RUN cycle, so redir, luh and halt are evaluated then.
- RUN->DRAIN per REQ-023.
- DRAIN->HALTED unconditionally after one cycle.
- HALTED is terminal until reset.
REQ-028 MEM_WAIT with mem_done=1 and exmem_halt=1 SHALL apply REQ-023 and go to DRAIN.
REQ-029 DRAIN: only memwb_en=1 (flush 0), so the HALT completes writeback; all other enables 0.
REQ-030 HALTED: all enables 0, all flushes 0, halted=1.
REQ-031 stall_cnt SHALL increment by 1 on each edge where pc_en==0 and state is RUN or MEM_WAIT; it SHALL hold at all 1s (no wrap) and hold in DRAIN and HALTED.
REQ-032 A redir held during mstall SHALL take effect on the release cycle, because the EX inputs are frozen.

Reset
REQ-033 On rst assertion, without waiting for clk: state=RUN, halted=0, stall_cnt=0.
REQ-034 While rst=1: all enables 0 and all flushes 0.
REQ-035 Reset asserted mid-MEM_WAIT or mid-DRAIN SHALL abandon the operation; after rst deasserts, the first cycle is normal RUN.

Verification
REQ-036 idex_memread=1, idex_wen=1, idex_rd=3, id_rs=3, id_rs_valid=1 -> pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1.
REQ-037 Same as REQ-036 plus ex_btake=1 -> all enables 1, ifid_flush=1, idex_flush=1, pc_en=1; stall_cnt unchanged.
REQ-038 exmem_memreq=1 with mem_done low for 3 cycles, then high -> MEM_WAIT for 3 cycles with memwb_flush=1; release cycle all enables 1; stall_cnt=3.
REQ-039 exmem_halt=1 in RUN -> exmem_flush=1; next cycle DRAIN (memwb_en only); then halted=1 held until rst.
REQ-040 CNT_W=4, stalls forced for 20 cycles -> stall_cnt saturates at 0xF; async rst mid-MEM_WAIT -> stall_cnt=0 and state RUN immediately.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: load-use interlock, branch redirect flush,
// data-memory wait stalls and a HALT drain sequence, with a saturating stall counter.
module pipe_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_rs_valid,
  input  logic             id_rt_valid,
  input  logic             idex_memread,
  input  logic             idex_wen,
  input  logic [2:0]       idex_rd,
  input  logic             ex_btake,
  input  logic             ex_jump,
  input  logic             exmem_memreq,
  input  logic             exmem_halt,
  input  logic             mem_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StMemWait, StDrain, StHalted} state_e;

  state_e           state_q, state_d;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic             luh, redir, mstall, fetch_state;

  assign luh = idex_memread & idex_wen &
               ((id_rs_valid & (id_rs == idex_rd)) | (id_rt_valid & (id_rt == idex_rd)));
  assign redir = ex_btake | ex_jump;
  // MEM_WAIT with mem_done is the release cycle and falls through to the RUN decisions.
  assign mstall = ((state_q == StRun) & exmem_memreq & ~mem_done) |
                  ((state_q == StMemWait) & ~mem_done);
  assign fetch_state = (state_q == StRun) | (state_q == StMemWait);

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (!rst) begin
      case (state_q)
        StRun, StMemWait: begin
          if (mstall) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
            if (state_q == StRun && !exmem_halt) state_d = StMemWait;
          end else if (exmem_halt) begin
            exmem_en    = 1'b1;
            exmem_flush = 1'b1;
            memwb_en    = 1'b1;
            state_d     = StDrain;
          end else if (redir) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            state_d    = StRun;
          end else if (luh) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            state_d    = StRun;
          end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            state_d  = StRun;
          end
        end
        StDrain: begin
          // Let the HALT itself finish writeback, then stop.
          memwb_en = 1'b1;
          state_d  = StHalted;
        end
        default: state_d = StHalted;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == StHalted);
      if (fetch_state && !pc_en && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign halted    = halted_q;
  assign stall_cnt = cnt_q;

endmodule
